// File: rtl/route_writer_if.sv
// Handshake/bus bundle for route_writer: pass control, route word input,
// route RAM write port and status flags.
interface route_writer_if #(
  parameter int WORDS  = 8,
  parameter int CITY_W = 7
);
  localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic                  start_i;
  logic                  in_valid_i;
  logic [8*CITY_W-1:0]   in_data_i;
  logic                  err_clr_i;
  logic                  ram_we_o;
  logic [AW-1:0]         ram_addr_o;
  logic [8*CITY_W-1:0]   ram_wdata_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  perm_ok_o;
  logic [1:0]            err_o;

  modport slave (
    input  start_i, in_valid_i, in_data_i, err_clr_i,
    output ram_we_o, ram_addr_o, ram_wdata_o, busy_o, done_o, perm_ok_o, err_o
  );

  modport master (
    output start_i, in_valid_i, in_data_i, err_clr_i,
    input  ram_we_o, ram_addr_o, ram_wdata_o, busy_o, done_o, perm_ok_o, err_o
  );
endinterface

// File: rtl/route_writer.sv
// Streams WORDS route words of 8 city lanes into the route RAM and checks
// that the pass forms a permutation of cities 0..WORDS*8-1.
module route_writer #(
  parameter int WORDS  = 8,
  parameter int CITY_W = 7
) (
  input  logic           clk,
  input  logic           rst_n,
  route_writer_if.slave  bus
);
  localparam int NC = WORDS * 8;
  localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_e;

  state_e                state_q;
  logic [AW-1:0]         cnt_q;
  logic [NC-1:0]         bm_q;
  logic                  fail_q;
  logic                  we_q;
  logic [AW-1:0]         addr_q;
  logic [8*CITY_W-1:0]   wdata_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  ok_q;
  logic [1:0]            err_q;

  logic                  acc_word;
  logic                  word_fail;
  logic [NC-1:0]         bm_d;
  logic [1:0]            err_d;
  logic [CITY_W-1:0]     lane_c;
  logic [NC-1:0]         oh_c;

  assign acc_word = (state_q == RECV) && bus.in_valid_i;

  // Lanes fold into the bitmap one after another, so a repeat inside the
  // word is caught by the same test as a repeat from an earlier word.
  always_comb begin
    bm_d      = bm_q;
    word_fail = 1'b0;
    lane_c    = '0;
    oh_c      = '0;
    for (int i = 0; i < 8; i++) begin
      lane_c = bus.in_data_i[i*CITY_W +: CITY_W];
      oh_c   = NC'(1) << lane_c;
      if ((32'(lane_c) >= 32'(NC)) || ((oh_c & bm_d) != '0))
        word_fail = 1'b1;
      bm_d = bm_d | oh_c;
    end
  end

  // A new error in the clearing cycle survives the clear.
  always_comb begin
    err_d = bus.err_clr_i ? 2'b00 : err_q;
    if (bus.in_valid_i && (state_q != RECV)) err_d[0] = 1'b1;
    if (bus.start_i && (state_q != IDLE))    err_d[1] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bm_q    <= '0;
      fail_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 2'b00;
    end else begin
      err_q  <= err_d;
      we_q   <= acc_word;
      done_q <= 1'b0;
      if (acc_word) begin
        addr_q  <= cnt_q;
        wdata_q <= bus.in_data_i;
      end
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            state_q <= RECV;
            cnt_q   <= '0;
            bm_q    <= '0;
            fail_q  <= 1'b0;
            ok_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        RECV: begin
          if (bus.in_valid_i) begin
            bm_q   <= bm_d;
            fail_q <= fail_q | word_fail;
            if (cnt_q == AW'(WORDS - 1)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              ok_q    <= ~(fail_q | word_fail);
            end else begin
              cnt_q <= cnt_q + AW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ram_we_o    = we_q;
  assign bus.ram_addr_o  = addr_q;
  assign bus.ram_wdata_o = wdata_q;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.perm_ok_o   = ok_q;
  assign bus.err_o       = err_q;
endmodule

// File: tb/tb_route_writer.sv
// Scoreboarded bench for route_writer: the driver queues expected writes and
// done events, a negedge monitor pops and compares them as the DUT emits them.
module tb_route_writer;
  localparam int WORDS  = 8;
  localparam int CITY_W = 7;
  localparam int DW     = 8 * CITY_W;

  typedef struct { int cyc; logic [2:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct { int cyc; bit ok; } dn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  wr_t  exp_wr[$];
  dn_t  exp_dn[$];

  route_writer_if #(.WORDS(WORDS), .CITY_W(CITY_W)) bus ();
  route_writer #(.WORDS(WORDS), .CITY_W(CITY_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every write and every done must match the head of its queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.ram_we_o) begin
        chk("write_expected", 64'(exp_wr.size() != 0), 64'd1);
        if (exp_wr.size() != 0) begin
          wr_t e;
          e = exp_wr.pop_front();
          chk("wr_cycle", 64'(cyc), 64'(e.cyc));
          chk("wr_addr", 64'(bus.ram_addr_o), 64'(e.a));
          chk("wr_data", 64'(bus.ram_wdata_o), 64'(e.d));
        end
      end
      if (bus.done_o) begin
        chk("done_expected", 64'(exp_dn.size() != 0), 64'd1);
        chk("done_with_last_we", 64'(bus.ram_we_o), 64'd1);
        if (exp_dn.size() != 0) begin
          dn_t e;
          e = exp_dn.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.cyc));
          chk("perm_ok", 64'(bus.perm_ok_o), 64'(e.ok));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Word w, lane i carries city 8w+i.
  function automatic logic [DW-1:0] mk_word(input int w);
    logic [DW-1:0] d;
    for (int i = 0; i < 8; i++) d[i*CITY_W +: CITY_W] = CITY_W'(8*w + i);
    return d;
  endfunction

  task automatic send_word(input int w, input logic [DW-1:0] d, input bit last, input bit ok);
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = d;
    exp_wr.push_back('{cyc + 1, 3'(w), d});
    if (last) exp_dn.push_back('{cyc + 1, ok});
    tick();
    bus.in_valid_i = 1'b0;
  endtask

  // One pass; mod_* patches one lane, start_at re-pulses start alongside that
  // word, stray drives in_valid together with the opening start.
  task automatic run_pass(input int gap_after, input int mod_w, input int mod_lane,
                          input int mod_val, input int start_at, input bit stray,
                          input bit exp_ok);
    logic [DW-1:0] d;
    int s, gaps;
    gaps = (gap_after >= 0) ? 3 : 0;
    bus.start_i    = 1'b1;
    bus.in_valid_i = stray;
    bus.in_data_i  = '1;
    s = cyc;
    tick();
    bus.start_i    = 1'b0;
    bus.in_valid_i = 1'b0;
    chk("busy_after_start", 64'(bus.busy_o), 64'd1);
    for (int w = 0; w < 8; w++) begin
      d = mk_word(w);
      if (w == mod_w) d[mod_lane*CITY_W +: CITY_W] = CITY_W'(mod_val);
      if (w == start_at) bus.start_i = 1'b1;
      send_word(w, d, w == 7, exp_ok);
      bus.start_i = 1'b0;
      if (w == gap_after) repeat (3) tick();
    end
    chk("done_latency", 64'(cyc - s), 64'(9 + gaps));
    tick();
    chk("busy_after_done", 64'(bus.busy_o), 64'd0);
    chk("done_single", 64'(bus.done_o), 64'd0);
    chk("perm_ok_held", 64'(bus.perm_ok_o), 64'(exp_ok));
  endtask

  task automatic clear_err();
    bus.err_clr_i = 1'b1;
    tick();
    bus.err_clr_i = 1'b0;
    chk("err_cleared", 64'(bus.err_o), 64'd0);
  endtask

  initial begin
    bus.start_i    = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.in_data_i  = '0;
    bus.err_clr_i  = 1'b0;
    repeat (3) tick();
    chk("rst_we", 64'(bus.ram_we_o), 64'd0);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    chk("rst_done", 64'(bus.done_o), 64'd0);
    chk("rst_perm_ok", 64'(bus.perm_ok_o), 64'd0);
    chk("rst_err", 64'(bus.err_o), 64'd0);
    chk("rst_addr", 64'(bus.ram_addr_o), 64'd0);
    chk("rst_wdata", 64'(bus.ram_wdata_o), 64'd0);
    rst_n = 1'b1;
    tick();

    // Clean back-to-back pass, then the same with a 3-cycle gap after word 3.
    run_pass(-1, -1, 0, 0, -1, 1'b0, 1'b1);
    run_pass(3, -1, 0, 0, -1, 1'b0, 1'b1);

    // Duplicate city 10 in word 5 lane 2, then a clean pass.
    run_pass(-1, 5, 2, 10, -1, 1'b0, 1'b0);
    run_pass(-1, -1, 0, 0, -1, 1'b0, 1'b1);
    chk("err_after_clean", 64'(bus.err_o), 64'd0);

    // Stray word in IDLE, then start during word 4.
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = '1;
    tick();
    bus.in_valid_i = 1'b0;
    chk("err_stray_idle", 64'(bus.err_o), 64'd1);
    run_pass(-1, -1, 0, 0, 4, 1'b0, 1'b1);
    chk("err_both", 64'(bus.err_o), 64'd3);
    clear_err();

    // Error set beats clear in the same cycle.
    bus.err_clr_i  = 1'b1;
    bus.in_valid_i = 1'b1;
    tick();
    bus.err_clr_i  = 1'b0;
    bus.in_valid_i = 1'b0;
    chk("err_set_wins", 64'(bus.err_o), 64'd1);
    clear_err();

    // start together with in_valid in IDLE: word dropped, pass still clean.
    run_pass(-1, -1, 0, 0, -1, 1'b1, 1'b1);
    chk("err_start_stray", 64'(bus.err_o), 64'd1);
    clear_err();

    // Out-of-range city 64.
    run_pass(-1, 2, 0, 64, -1, 1'b0, 1'b0);
    chk("err_unchanged_range", 64'(bus.err_o), 64'd0);

    // Abort after word 3 with reset.
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    for (int w = 0; w < 4; w++) send_word(w, mk_word(w), 1'b0, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort_we", 64'(bus.ram_we_o), 64'd0);
    chk("abort_busy", 64'(bus.busy_o), 64'd0);
    repeat (2) tick();
    chk("abort_done", 64'(bus.done_o), 64'd0);
    rst_n = 1'b1;
    repeat (4) tick();
    chk("idle_after_rst_busy", 64'(bus.busy_o), 64'd0);
    run_pass(-1, -1, 0, 0, -1, 1'b0, 1'b1);

    repeat (3) tick();
    chk("writes_drained", 64'(exp_wr.size()), 64'd0);
    chk("dones_drained", 64'(exp_dn.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/route_writer.md
ROUTE_WRITER -- requirements
Module: route_writer

Interface
REQ-001 Parameter WORDS, default 8: number of 8-lane route words per pass; the route holds WORDS*8 cities.
REQ-002 Parameter CITY_W, default 7: width of one city index lane.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle pulse that opens one store pass.
REQ-006 in_valid  input  1  in_data carries one route word this cycle.
REQ-007 in_data  input  8*CITY_W  lane i in bits [i*CITY_W +: CITY_W]; lane 0 is the lowest-order city of the word.
REQ-008 err_clr  input  1  clears the sticky error bits.
REQ-009 ram_we  output  1  route RAM write strobe.
REQ-010 ram_addr  output  $clog2(WORDS)  route RAM word address.
REQ-011 ram_wdata  output  8*CITY_W  route RAM write data.
REQ-012 busy  output  1  high from the cycle after an accepted start until done is asserted.
REQ-013 done  output  1  single-cycle pulse marking the end of a pass.
REQ-014 perm_ok  output  1  result of the permutation check, valid while done=1 and held until the next start.
REQ-015 err  output  2  sticky flags: bit0 = stray in_valid, bit1 = start while busy.

Function
REQ-016 FSM states: IDLE, RECV, DONE.
- IDLE->RECV on start.
- RECV->DONE in the cycle the WORDS-th word is accepted.
- DONE->IDLE unconditionally after one cycle.
REQ-017 Word counter:
- Cleared to 0 on an accepted start.
- Increments by 1 per accepted word in RECV.
- Compared against WORDS-1 to end the pass; never wraps within a pass.
REQ-018 A word is accepted when in_valid=1 in RECV; there is no backpressure, and idle cycles between words are allowed.
REQ-019 Write timing, 1-cycle latency: for a word accepted at cycle n, ram_we=1 at cycle n+1 with ram_addr = counter value at n and ram_wdata = in_data registered at n.
REQ-020 ram_we is 0 in every cycle not covered by REQ-019; ram_addr and ram_wdata are don't-care when ram_we=0.
REQ-021 Permutation check bitmap:
- One bit per city index 0..WORDS*8-1, cleared on an accepted start.
- For each accepted word, each lane sets its index bit.
REQ-022 A pass-local fail flag, cleared on an accepted start, is set if any lane index is >= WORDS*8, if its bitmap bit is already set, or if two lanes of the same word carry equal indices.
REQ-023 perm_ok is registered on DONE entry as NOT fail; done=1 exactly in the DONE cycle.
REQ-024 The final write (ram_we for the last word) occurs in the same cycle as done=1.
REQ-025 start in RECV or DONE is ignored and sets err[1]; the pass is unaffected.
REQ-026 in_valid in IDLE or DONE is dropped (no write) and sets err[0].
REQ-027 err_clr clears both err bits; if an error set and err_clr occur in the same cycle, the set wins.
REQ-028 start and in_valid in the same IDLE cycle: start is accepted and the word is dropped with err[0] set; the first data word is taken no earlier than the following cycle.

Reset
REQ-029 While reset=0:
- FSM = IDLE, counter = 0, bitmap = 0, fail = 0.
- ram_we = 0, busy = 0, done = 0, perm_ok = 0, err = 2'b00.
- ram_addr = 0, ram_wdata = 0.
REQ-030 Reset asserted mid-pass aborts the pass: no further ram_we, and no done for that pass.
REQ-031 After reset release, the block waits in IDLE for a new start.

Verification
REQ-032 WORDS=8. start, then 8 back-to-back words whose lane i of word w = 8w+i -> ram_we at addr 0..7 on cycles 2..9 after start; done=1 and perm_ok=1 on cycle 9; busy=0 on cycle 10.
REQ-033 Same pass with a 3-cycle gap after word 3 -> addresses stay consecutive 0..7, done is delayed by 3 cycles, perm_ok=1.
REQ-034 Word 5 lane 2 = 10 (duplicate of word 1 lane 2) -> all 8 writes occur, done=1, perm_ok=0; a following clean pass gives perm_ok=1.
REQ-035 in_valid in IDLE, then start asserted during word 4 of a pass -> err=2'b11, no extra write, the pass completes normally; err_clr -> err=2'b00 next cycle.
REQ-036 reset low after word 3, then released, then a clean pass -> no write after reset, no done for the aborted pass; the new pass writes addr 0..7 and gives perm_ok=1.
REQ-037 Lane value 64 (out of range) -> perm_ok=0; err unchanged.
